morse_round_ctrl: RTL and testbench
===================================

# morse_round_ctrl

Round sequencer for the Morse-code game. Collects dot/dash key pulses for one letter, compares the entry against the current target code on submit, and issues one-cycle `vict` pulses to the 7-segment victory counter on each correct letter. Tracks score up to the win count, enforces a lockout after a miss, and pulses a display reset when a new game starts. Sits between the key debouncers and target-letter ROM on one side and the victory display counter on the other.

## Interface
- `MAX_LEN`, 4: maximum symbols per letter; legal range 1..7.
- `WIN_COUNT`, 7: correct letters needed to win; legal range 1..7.
- `LOCKOUT_CYCLES`, 50: cycles spent in LOCKOUT after a miss; must be ≥1.
- `TIMEOUT_CYCLES`, 100: idle-entry auto-submit delay; used only with `ROUND_TIMEOUT_EN`.

- `Clock`  in  1  single clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; starts a new game.
- `dot`  in  1  one-cycle pulse; enter a dot (0).
- `dash`  in  1  one-cycle pulse; enter a dash (1).
- `submit`  in  1  one-cycle pulse; end of letter, request check.
- `target_code`  in  MAX_LEN  expected symbols; bit 0 is the first symbol.
- `target_len`  in  3  expected symbol count, 1..MAX_LEN.
- `vict`  out  1  one-cycle pulse per correct letter; drives the victory counter.
- `miss`  out  1  one-cycle pulse per wrong letter.
- `disp_reset`  out  1  one-cycle pulse clearing the victory display.
- `score`  out  3  correct letters this game.
- `entry_len`  out  3  symbols captured so far.
- `busy`  out  1  high in CHECK, RESULT and LOCKOUT.
- `game_over`  out  1  high in DONE.

## Operation
- States: IDLE, ENTRY, CHECK, RESULT, LOCKOUT, DONE.
- IDLE: `start` moves to ENTRY, pulses `disp_reset`, and clears score, entry and overflow. All other inputs are ignored.
- ENTRY, symbol capture: a `dot` or `dash` alone writes bit `entry_len` and increments `entry_len`.
  - `dot` and `dash` together are both ignored.
  - A symbol arriving when `entry_len == MAX_LEN` is dropped and sets a sticky `overflow`.
- ENTRY, submit: `submit` moves to CHECK. A `dot`/`dash` in the same cycle is discarded. Submit with `entry_len == 0` is ignored.
- CHECK: match = !overflow && `entry_len == target_len` && the low `entry_len` bits of entry equal `target_code`. `target_*` are sampled in this cycle. Always goes to RESULT.
- RESULT, on match: pulse `vict`, increment `score`, clear entry and overflow.
  - If the new score equals `WIN_COUNT`, go to DONE; otherwise go to ENTRY.
- RESULT, on mismatch: pulse `miss`, clear entry and overflow, load the lockout counter with `LOCKOUT_CYCLES`, go to LOCKOUT.
- LOCKOUT: `dot`, `dash` and `submit` are ignored. Counter decrements each cycle; at 0, go to ENTRY.
- DONE: holds `game_over`, score frozen. `start` behaves as it does in IDLE. Other inputs are ignored.
- `start` in ENTRY, CHECK, RESULT or LOCKOUT is ignored.
- Score never exceeds `WIN_COUNT`; no wrap-around.

## Timing
- Reset: state IDLE. `vict`, `miss`, `disp_reset`, `busy`, `game_over` = 0. `score` = 0, `entry_len` = 0, overflow = 0, counters = 0.
- Reset mid-game has the same effect; no pulse is emitted in the reset cycle.
- `submit` sampled at edge N: CHECK during N+1, `vict`/`miss` high for exactly cycle N+2, next state from edge N+3.
- `score` updates in the same cycle `vict` is high. `game_over` rises one cycle after the winning `vict`.
- `disp_reset` is high in the cycle after `start` is sampled, coincident with entering ENTRY.
- LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles; the first accepted symbol is in the following cycle.
- All outputs are registered.

## Configuration
- `ROUND_TIMEOUT_EN` defined:
  - In ENTRY with `entry_len > 0`, a counter counts cycles with no `dot`/`dash`.
  - Any accepted symbol reloads it.
  - Reaching `TIMEOUT_CYCLES` acts exactly as `submit`, with the same CHECK/RESULT timing from that cycle.
- Not defined: no timeout logic; only `submit` ends a letter.

## Test plan
- Reset then `start`: `disp_reset` pulses once, state ENTRY, `score` = 0, `vict` = 0.
- Target `target_code = 4'b0010`, `target_len = 3`; enter dot, dash, dot, then submit at cycle N: `vict` = 1 only in N+2, `score` = 1.
- Same target, enter dash, dot, dot: `miss` at N+2, `busy` high for 1 + 1 + `LOCKOUT_CYCLES` cycles, and symbols during LOCKOUT leave `entry_len` = 0.
- 5 symbols with `MAX_LEN = 4`, where the first 4 match a 4-symbol target: overflow forces `miss`.
- Seven consecutive correct letters: seven `vict` pulses, `score` = 7, `game_over` = 1. A further submit gives no pulse; `start` restarts with `score` = 0.
- Assert `Reset` during LOCKOUT: next cycle IDLE, all outputs 0. With `ROUND_TIMEOUT_EN`, one dot then idle for `TIMEOUT_CYCLES` gives an auto-check and a correct `vict` when the target is a single dot.

Source files
------------

// File: rtl/morse_round_ctrl.sv
// Morse-code game round sequencer: captures dot/dash symbols, checks them against the target letter,
// scores correct letters and locks out after a miss. Define ROUND_TIMEOUT_EN to auto-submit an idle entry.
module morse_round_ctrl #(
  parameter int MAX_LEN        = 4,
  parameter int WIN_COUNT      = 7,
  parameter int LOCKOUT_CYCLES = 50,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               start,
  input  logic               dot,
  input  logic               dash,
  input  logic               submit,
  input  logic [MAX_LEN-1:0] target_code,
  input  logic [2:0]         target_len,
  output logic               vict,
  output logic               miss,
  output logic               disp_reset,
  output logic [2:0]         score,
  output logic [2:0]         entry_len,
  output logic               busy,
  output logic               game_over,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    RESULT  = 3'd3,
    LOCKOUT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

  // Handshake: start/dot/dash/submit are single-cycle strobes sampled on the
  // rising edge with no ready; a strobe arriving in a state that ignores it is lost.

  state_t               state, state_n;
  logic [MAX_LEN-1:0]   entry, entry_n;
  logic [2:0]           entry_len_n, score_n;
  logic                 overflow, overflow_n;
  logic                 match_r, match_n;
  logic [LW-1:0]        lock_cnt, lock_n;
  logic                 vict_n, miss_n, disp_n, busy_n, over_n;
  logic                 sym, hit, end_letter;

  assign sym       = dot ^ dash;
  assign state_dbg = state;

`ifdef ROUND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;

  // Counts idle cycles once the letter has at least one symbol; the
  // TIMEOUT_CYCLES-th idle cycle is treated as a submit strobe.
  assign timeout_hit = (state == ENTRY) && (entry_len != 3'd0) && !sym &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign end_letter  = submit || timeout_hit;

  always_ff @(posedge Clock) begin
    if (Reset)                                         to_cnt <= '0;
    else if (state != ENTRY || entry_len == 3'd0 || sym) to_cnt <= '0;
    else                                                to_cnt <= to_cnt + TW'(1);
  end
`else
  assign end_letter = submit;
`endif

  // Compare only the symbols actually entered; bits above entry_len are don't-care.
  always_comb begin
    hit = !overflow && (entry_len == target_len);
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(entry_len) && entry[i] != target_code[i]) hit = 1'b0;
    end
  end

  always_comb begin
    state_n     = state;
    entry_n     = entry;
    entry_len_n = entry_len;
    overflow_n  = overflow;
    score_n     = score;
    lock_n      = lock_cnt;
    match_n     = match_r;
    vict_n      = 1'b0;
    miss_n      = 1'b0;
    disp_n      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = ENTRY;
          disp_n      = 1'b1;
          score_n     = 3'd0;
          entry_n     = '0;
          entry_len_n = 3'd0;
          overflow_n  = 1'b0;
        end
      end
      ENTRY: begin
        if (end_letter && entry_len != 3'd0) begin
          state_n = CHECK;
        end else if (sym) begin
          if (entry_len == 3'(MAX_LEN)) begin
            overflow_n = 1'b1;
          end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (i == int'(entry_len)) entry_n[i] = dash;
            end
            entry_len_n = entry_len + 3'd1;
          end
        end
      end
      CHECK: begin
        // The verdict is registered here so vict/miss and score land together in RESULT.
        state_n     = RESULT;
        match_n     = hit;
        vict_n      = hit;
        miss_n      = !hit;
        entry_n     = '0;
        entry_len_n = 3'd0;
        overflow_n  = 1'b0;
        if (hit && score != 3'(WIN_COUNT)) score_n = score + 3'd1;
        if (!hit) lock_n = LOCK_LOAD;
      end
      RESULT: begin
        if (!match_r)                      state_n = LOCKOUT;
        else if (score == 3'(WIN_COUNT))   state_n = DONE;
        else                               state_n = ENTRY;
      end
      LOCKOUT: begin
        lock_n = lock_cnt - LW'(1);
        if (lock_cnt <= LW'(1)) state_n = ENTRY;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == CHECK) || (state_n == RESULT) || (state_n == LOCKOUT);
    over_n = (state_n == DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      entry      <= '0;
      entry_len  <= 3'd0;
      overflow   <= 1'b0;
      score      <= 3'd0;
      lock_cnt   <= '0;
      match_r    <= 1'b0;
      vict       <= 1'b0;
      miss       <= 1'b0;
      disp_reset <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      entry      <= entry_n;
      entry_len  <= entry_len_n;
      overflow   <= overflow_n;
      score      <= score_n;
      lock_cnt   <= lock_n;
      match_r    <= match_n;
      vict       <= vict_n;
      miss       <= miss_n;
      disp_reset <= disp_n;
      busy       <= busy_n;
      game_over  <= over_n;
    end
  end

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Directed bench for morse_round_ctrl; covers the ROUND_TIMEOUT_EN path when that macro is defined.
module tb_morse_round_ctrl;

  localparam int MAX_LEN = 4;
  localparam int LOCK    = 50;
  localparam int TMO     = 100;

  localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_CHECK = 3'd2,
                         S_RESULT = 3'd3, S_LOCKOUT = 3'd4, S_DONE = 3'd5;

  logic               Clock, Reset;
  logic               start, dot, dash, submit;
  logic [MAX_LEN-1:0] target_code;
  logic [2:0]         target_len;
  logic               vict, miss, disp_reset, busy, game_over;
  logic [2:0]         score, entry_len, state_dbg;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  morse_round_ctrl #(
    .MAX_LEN(MAX_LEN), .WIN_COUNT(7), .LOCKOUT_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .dot(dot), .dash(dash),
    .submit(submit), .target_code(target_code), .target_len(target_len),
    .vict(vict), .miss(miss), .disp_reset(disp_reset), .score(score),
    .entry_len(entry_len), .busy(busy), .game_over(game_over), .state_dbg(state_dbg)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic d, input logic s);
    dot = d; dash = s;
    tick();
    dot = 1'b0; dash = 1'b0;
  endtask

  task automatic do_submit();
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; start = 0; dot = 0; dash = 0; submit = 0;
    target_code = '0; target_len = 3'd1;
    tick(); tick();
    Reset = 1'b0;

    // reset state
    check("rst_state", 8'(state_dbg), 8'(S_IDLE));
    check("rst_vict", 8'(vict), 8'd0);
    check("rst_miss", 8'(miss), 8'd0);
    check("rst_disp", 8'(disp_reset), 8'd0);
    check("rst_score", 8'(score), 8'd0);
    check("rst_len", 8'(entry_len), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_over", 8'(game_over), 8'd0);

    // inputs other than start are ignored in IDLE
    key(1'b1, 1'b0);
    check("idle_ign_len", 8'(entry_len), 8'd0);
    check("idle_ign_state", 8'(state_dbg), 8'(S_IDLE));

    // start
    do_start();
    check("start_disp", 8'(disp_reset), 8'd1);
    check("start_state", 8'(state_dbg), 8'(S_ENTRY));
    check("start_score", 8'(score), 8'd0);
    check("start_vict", 8'(vict), 8'd0);
    tick();
    check("start_disp_once", 8'(disp_reset), 8'd0);

    // correct letter: dot, dash, dot vs 0010 / 3
    target_code = 4'b0010; target_len = 3'd3;
    key(1'b1, 1'b0); key(1'b0, 1'b1); key(1'b1, 1'b0);
    check("hit_len", 8'(entry_len), 8'd3);
    do_submit();
    check("hit_n1_state", 8'(state_dbg), 8'(S_CHECK));
    check("hit_n1_vict", 8'(vict), 8'd0);
    check("hit_n1_busy", 8'(busy), 8'd1);
    tick();
    check("hit_n2_vict", 8'(vict), 8'd1);
    check("hit_n2_score", 8'(score), 8'd1);
    check("hit_n2_miss", 8'(miss), 8'd0);
    tick();
    check("hit_n3_vict", 8'(vict), 8'd0);
    check("hit_n3_state", 8'(state_dbg), 8'(S_ENTRY));
    check("hit_n3_busy", 8'(busy), 8'd0);

    // wrong letter: dash, dot, dot -> miss and lockout
    key(1'b0, 1'b1); key(1'b1, 1'b0); key(1'b1, 1'b0);
    do_submit();
    check("miss_n1_busy", 8'(busy), 8'd1);
    check("miss_n1_miss", 8'(miss), 8'd0);
    tick();
    check("miss_n2_miss", 8'(miss), 8'd1);
    check("miss_n2_vict", 8'(vict), 8'd0);
    check("miss_n2_score", 8'(score), 8'd1);
    check("miss_n2_busy", 8'(busy), 8'd1);
    for (int i = 0; i < LOCK; i++) begin
      dot = 1'b1;
      submit = (i == 3);
      tick();
      check($sformatf("lock_busy_%0d", i), 8'(busy), 8'd1);
      check($sformatf("lock_len_%0d", i), 8'(entry_len), 8'd0);
    end
    submit = 1'b0;
    tick();
    check("lock_exit_busy", 8'(busy), 8'd0);
    check("lock_exit_state", 8'(state_dbg), 8'(S_ENTRY));
    check("lock_exit_len", 8'(entry_len), 8'd0);
    tick();
    dot = 1'b0;
    check("lock_first_sym", 8'(entry_len), 8'd1);

    // that single dot scores against a one-dot target
    target_code = 4'b0000; target_len = 3'd1;
    do_submit(); tick();
    check("dot_vict", 8'(vict), 8'd1);
    check("dot_score", 8'(score), 8'd2);
    tick();

    // overflow: five symbols, first four match 1010 / 4
    target_code = 4'b1010; target_len = 3'd4;
    key(1'b1, 1'b0); key(1'b0, 1'b1); key(1'b1, 1'b0); key(1'b0, 1'b1); key(1'b1, 1'b0);
    check("ovf_len", 8'(entry_len), 8'd4);
    do_submit(); tick();
    check("ovf_miss", 8'(miss), 8'd1);
    check("ovf_vict", 8'(vict), 8'd0);
    check("ovf_score", 8'(score), 8'd2);
    repeat (LOCK) tick();
    check("ovf_lock_last", 8'(busy), 8'd1);
    tick();
    check("ovf_lock_done", 8'(busy), 8'd0);
    key(1'b1, 1'b0); key(1'b0, 1'b1); key(1'b1, 1'b0); key(1'b0, 1'b1);
    do_submit(); tick();
    check("four_vict", 8'(vict), 8'd1);
    check("four_score", 8'(score), 8'd3);
    tick();

    // both keys together and empty submit are ignored; start ignored in ENTRY
    key(1'b1, 1'b1);
    check("both_len", 8'(entry_len), 8'd0);
    do_submit();
    check("empty_sub_state", 8'(state_dbg), 8'(S_ENTRY));
    do_start();
    check("entry_start_disp", 8'(disp_reset), 8'd0);

    // four more single-dash letters to reach the win count
    target_code = 4'b0001; target_len = 3'd1;
    for (int k = 0; k < 4; k++) begin
      key(1'b0, 1'b1);
      do_submit(); tick();
      check($sformatf("win_vict_%0d", k), 8'(vict), 8'd1);
      check($sformatf("win_score_%0d", k), 8'(score), 8'(4 + k));
      check($sformatf("win_over_pre_%0d", k), 8'(game_over), 8'd0);
      tick();
      check($sformatf("win_over_%0d", k), 8'(game_over), (k == 3) ? 8'd1 : 8'd0);
    end
    check("done_state", 8'(state_dbg), 8'(S_DONE));

    // DONE ignores further letters
    key(1'b0, 1'b1);
    do_submit();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("done_vict_%0d", i), 8'(vict), 8'd0);
      check($sformatf("done_score_%0d", i), 8'(score), 8'd7);
      check($sformatf("done_over_%0d", i), 8'(game_over), 8'd1);
    end
    do_start();
    check("restart_disp", 8'(disp_reset), 8'd1);
    check("restart_score", 8'(score), 8'd0);
    check("restart_over", 8'(game_over), 8'd0);
    check("restart_state", 8'(state_dbg), 8'(S_ENTRY));

    // reset during lockout
    target_code = 4'b0010; target_len = 3'd3;
    key(1'b0, 1'b1);
    do_submit(); tick();
    check("rl_miss", 8'(miss), 8'd1);
    tick(); tick();
    check("rl_lock", 8'(state_dbg), 8'(S_LOCKOUT));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rl_state", 8'(state_dbg), 8'(S_IDLE));
    check("rl_busy", 8'(busy), 8'd0);
    check("rl_miss0", 8'(miss), 8'd0);
    check("rl_vict", 8'(vict), 8'd0);
    check("rl_disp", 8'(disp_reset), 8'd0);
    check("rl_score", 8'(score), 8'd0);
    check("rl_len", 8'(entry_len), 8'd0);

`ifdef ROUND_TIMEOUT_EN
    // one dot, then idle until the auto-submit fires
    do_start();
    target_code = 4'b0000; target_len = 3'd1;
    key(1'b1, 1'b0);
    repeat (TMO - 1) tick();
    check("tmo_wait_state", 8'(state_dbg), 8'(S_ENTRY));
    tick();
    check("tmo_check_state", 8'(state_dbg), 8'(S_CHECK));
    tick();
    check("tmo_vict", 8'(vict), 8'd1);
    check("tmo_score", 8'(score), 8'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
